// File: rtl/coproc_dispatch.sv
// -----------------------------------------------------------------------------
// coproc_dispatch
//
// Hands one instruction at a time from the core to one of NUM_CP attached
// coprocessor channels. It stalls the core (pc_en=0) while the channel is
// reset, started and waited on, then retires the channel's result for
// register-file writeback.
//
// Sequence: IDLE -> RST -> START -> WAIT -> DONE -> IDLE
//   An issue to a channel index >= NUM_CP goes straight from IDLE to DONE
//   and retires with error=1 and result=0.
//
// Optional feature (macro CP_TIMEOUT_EN):
//   When defined, WAIT gives up after TIMEOUT cycles without cp_done[sel]
//   and retires with error=1, result=0. When undefined, WAIT waits forever
//   (until cp_done[sel] or reset) and no counter exists.
//
// Ports
//   clk           in   clock, all state updates on the rising edge
//   reset         in   synchronous active-high reset
//   issue         in   core requests a coprocessor operation
//   cp_sel        in   target channel index ($clog2(NUM_CP) bits)
//   op            in   opcode forwarded to the channel (OPW bits)
//   src_a, src_b  in   operands (WIDTH bits)
//   pc_en         out  PC enable, 0 stalls the core
//   result        out  registered result (WIDTH bits)
//   result_valid  out  one-cycle retire pulse
//   error         out  one-cycle failure flag, coincident with result_valid
//   cp_reset      out  one-hot per-channel reset pulse
//   cp_start      out  one-hot per-channel start pulse
//   cp_op         out  latched opcode, shared by all channels
//   cp_a, cp_b    out  latched operands, shared by all channels
//   cp_done       in   per-channel completion level
//   cp_result     in   channel i result on bits [i*WIDTH +: WIDTH]
// -----------------------------------------------------------------------------
module coproc_dispatch #(
  parameter int WIDTH   = 32,
  parameter int NUM_CP  = 4,
  parameter int OPW     = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue,
  input  logic [$clog2(NUM_CP)-1:0] cp_sel,
  input  logic [OPW-1:0]            op,
  input  logic [WIDTH-1:0]          src_a,
  input  logic [WIDTH-1:0]          src_b,
  output logic                      pc_en,
  output logic [WIDTH-1:0]          result,
  output logic                      result_valid,
  output logic                      error,
  output logic [NUM_CP-1:0]         cp_reset,
  output logic [NUM_CP-1:0]         cp_start,
  output logic [OPW-1:0]            cp_op,
  output logic [WIDTH-1:0]          cp_a,
  output logic [WIDTH-1:0]          cp_b,
  input  logic [NUM_CP-1:0]         cp_done,
  input  logic [NUM_CP*WIDTH-1:0]   cp_result
);

  localparam int SW = $clog2(NUM_CP);
  // One extra bit so NUM_CP itself is representable for the range check.
  localparam logic [SW:0] NUM_CP_W = (SW+1)'(NUM_CP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t              state_q;
  logic [NUM_CP-1:0]   sel_oh_d;      // one-hot decode of the incoming cp_sel
  logic [NUM_CP-1:0]   sel_oh_q;      // latched channel, kept one-hot
  logic [NUM_CP-1:0]   cp_reset_q;
  logic [NUM_CP-1:0]   cp_start_q;
  logic [OPW-1:0]      cp_op_q;
  logic [WIDTH-1:0]    cp_a_q;
  logic [WIDTH-1:0]    cp_b_q;
  logic [WIDTH-1:0]    result_q;
  logic                result_valid_q;
  logic                error_q;
  logic                sel_invalid;
  logic                done_sel;
  logic [WIDTH-1:0]    result_sel;

  if (NUM_CP < 2 || TIMEOUT < 1) begin : g_param_check
    $error("coproc_dispatch: NUM_CP must be >= 2 and TIMEOUT >= 1");
  end

  // Channel decode for the incoming index and for the latched one.
  for (genvar gi = 0; gi < NUM_CP; gi++) begin : g_sel_dec
    assign sel_oh_d[gi] = (cp_sel == SW'(gi));
  end

  assign sel_invalid = ({1'b0, cp_sel} >= NUM_CP_W);

  // Only the latched channel's done and result are ever looked at.
  assign done_sel = |(cp_done & sel_oh_q);

  always_comb begin
    result_sel = '0;
    for (int i = 0; i < NUM_CP; i++) begin
      result_sel = result_sel | (cp_result[i*WIDTH +: WIDTH] & {WIDTH{sel_oh_q[i]}});
    end
  end

`ifdef CP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] timer_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      sel_oh_q       <= '0;
      cp_reset_q     <= '0;
      cp_start_q     <= '0;
      cp_op_q        <= '0;
      cp_a_q         <= '0;
      cp_b_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
`ifdef CP_TIMEOUT_EN
      timer_q        <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            sel_oh_q <= sel_oh_d;
            cp_op_q  <= op;
            cp_a_q   <= src_a;
            cp_b_q   <= src_b;
            if (sel_invalid) begin
              // No channel exists: skip straight to retire with an error.
              state_q        <= ST_DONE;
              result_q       <= '0;
              result_valid_q <= 1'b1;
              error_q        <= 1'b1;
            end else begin
              state_q    <= ST_RST;
              cp_reset_q <= sel_oh_d;
            end
          end
        end
        ST_RST: begin
          cp_reset_q <= '0;
          cp_start_q <= sel_oh_q;
          state_q    <= ST_START;
        end
        ST_START: begin
          cp_start_q <= '0;
          state_q    <= ST_WAIT;
`ifdef CP_TIMEOUT_EN
          timer_q    <= '0;
`endif
        end
        ST_WAIT: begin
          if (done_sel) begin
            result_q       <= result_sel;
            result_valid_q <= 1'b1;
            error_q        <= 1'b0;
            state_q        <= ST_DONE;
          end
`ifdef CP_TIMEOUT_EN
          else if (timer_q == TIMER_LAST) begin
            result_q       <= '0;
            result_valid_q <= 1'b1;
            error_q        <= 1'b1;
            state_q        <= ST_DONE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`else
          // No time limit: stay here until the channel answers or reset.
`endif
        end
        ST_DONE: begin
          result_valid_q <= 1'b0;
          error_q        <= 1'b0;
          state_q        <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall is combinational on issue so the core freezes in the issue cycle.
  assign pc_en = reset |
                 ~((state_q == ST_IDLE && issue) || state_q == ST_RST ||
                   state_q == ST_START || state_q == ST_WAIT);

  // Outputs are forced quiet for the whole reset cycle, not just after it.
  assign result       = reset ? '0   : result_q;
  assign result_valid = reset ? 1'b0 : result_valid_q;
  assign error        = reset ? 1'b0 : error_q;
  assign cp_reset     = reset ? '0   : cp_reset_q;
  assign cp_start     = reset ? '0   : cp_start_q;
  assign cp_op        = reset ? '0   : cp_op_q;
  assign cp_a         = reset ? '0   : cp_a_q;
  assign cp_b         = reset ? '0   : cp_b_q;

endmodule

// File: tb/tb_coproc_dispatch.sv
// -----------------------------------------------------------------------------
// tb_coproc_dispatch
//
// Five channels are instantiated so that a 3-bit cp_sel can name channels
// that do not exist (5..7) while channel 3 still exists.
// Expected retires {error, result} are queued when an operation is issued
// and popped by the monitor whenever result_valid is seen.
// -----------------------------------------------------------------------------
module tb_coproc_dispatch;

  localparam int WIDTH   = 32;
  localparam int NUM_CP  = 5;
  localparam int OPW     = 2;
  localparam int TIMEOUT = 8;
  localparam int SW      = $clog2(NUM_CP);

  logic                    clk;
  logic                    reset;
  logic                    issue;
  logic [SW-1:0]           cp_sel;
  logic [OPW-1:0]          op;
  logic [WIDTH-1:0]        src_a;
  logic [WIDTH-1:0]        src_b;
  logic                    pc_en;
  logic [WIDTH-1:0]        result;
  logic                    result_valid;
  logic                    error;
  logic [NUM_CP-1:0]       cp_reset;
  logic [NUM_CP-1:0]       cp_start;
  logic [OPW-1:0]          cp_op;
  logic [WIDTH-1:0]        cp_a;
  logic [WIDTH-1:0]        cp_b;
  logic [NUM_CP-1:0]       cp_done;
  logic [NUM_CP*WIDTH-1:0] cp_result;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] sb[$];   // {error, result}

  coproc_dispatch #(
    .WIDTH(WIDTH), .NUM_CP(NUM_CP), .OPW(OPW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .issue(issue), .cp_sel(cp_sel), .op(op),
    .src_a(src_a), .src_b(src_b), .pc_en(pc_en), .result(result),
    .result_valid(result_valid), .error(error), .cp_reset(cp_reset),
    .cp_start(cp_start), .cp_op(cp_op), .cp_a(cp_a), .cp_b(cp_b),
    .cp_done(cp_done), .cp_result(cp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor and one-hot pulse check.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ($countones(cp_reset) > 1 || $countones(cp_start) > 1) begin
        errors++;
        $display("FAIL onehot: cp_reset=%b cp_start=%b, required at most one bit each",
                 cp_reset, cp_start);
      end
      if (result_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_retire: result_valid=1 result=%h error=%b, required no retire",
                   result, error);
        end else begin
          logic [WIDTH:0] exp;
          exp = sb.pop_front();
          if ({error, result} !== exp) begin
            errors++;
            $display("FAIL retire: error=%b result=%h, required error=%b result=%h",
                     error, result, exp[WIDTH], exp[WIDTH-1:0]);
          end
        end
      end
    end
  end

  // Drives one operation; returns stall cycles and any channel pulses seen.
  task automatic do_op(input int sel, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] res, input bit exp_err, input int done_at,
                       input logic [NUM_CP-1:0] other, input bit push, input int budget,
                       output int stalls, output logic [NUM_CP-1:0] rst_seen,
                       output logic [NUM_CP-1:0] start_seen);
    logic [NUM_CP-1:0] so;
    int k;
    so = '0;
    if (sel < NUM_CP) so[sel] = 1'b1;
    @(posedge clk); #1;
    issue  = 1'b1;
    cp_sel = sel[SW-1:0];
    op     = OPW'($urandom);
    src_a  = a;
    src_b  = b;
    for (int i = 0; i < NUM_CP; i++)
      cp_result[i*WIDTH +: WIDTH] = (i == sel) ? res : WIDTH'($urandom);
    cp_done = other | ((done_at <= 0) ? so : '0);
    if (push) sb.push_back({exp_err, exp_err ? {WIDTH{1'b0}} : res});
    stalls = 0; rst_seen = '0; start_seen = '0; k = 0;
    while (stalls < budget) begin
      @(negedge clk);
      rst_seen   = rst_seen | cp_reset;
      start_seen = start_seen | cp_start;
      if (pc_en) break;
      stalls++;
      @(posedge clk); #1;
      k++;
      // Mid-operation input churn must not disturb the operation.
      issue   = 1'($urandom);
      cp_sel  = SW'($urandom);
      op      = OPW'($urandom);
      src_a   = WIDTH'($urandom);
      src_b   = WIDTH'($urandom);
      cp_done = other | ((k >= done_at) ? so : '0);
    end
    issue = 1'b0;
    $display("op sel=%0d a=%h b=%h stalls=%0d result=%h error=%b", sel, a, b, stalls, result, error);
  endtask

  task automatic test_reset();
    reset = 1'b1; issue = 1'b0; cp_sel = '0; op = '0; src_a = '0; src_b = '0;
    cp_done = '0; cp_result = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL rst_pc_en: got %b required 1", pc_en); end
    checks++; if (result !== '0) begin errors++; $display("FAIL rst_result: got %h required 0", result); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", result_valid); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b required 0", error); end
    checks++; if (cp_reset !== '0 || cp_start !== '0) begin errors++; $display("FAIL rst_pulses: cp_reset=%b cp_start=%b required 0", cp_reset, cp_start); end
    checks++; if (cp_op !== '0 || cp_a !== '0 || cp_b !== '0) begin errors++; $display("FAIL rst_operands: op=%h a=%h b=%h required 0", cp_op, cp_a, cp_b); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (pc_en !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL idle_after_rst: pc_en=%b valid=%b required 1/0", pc_en, result_valid); end
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    issue = 1'b1; cp_sel = 3'd2; op = 2'd1; src_a = 32'd7; src_b = 32'd5;
    for (int i = 0; i < NUM_CP; i++) cp_result[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    sb.push_back({1'b0, 32'd12});
    @(negedge clk);
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL basic_issue_stall: pc_en=%b required 0", pc_en); end
    @(posedge clk); #1;
    issue = 1'b0; cp_sel = 3'd0; src_a = 32'd99; src_b = 32'd98; op = 2'd3;
    @(negedge clk);
    checks++; if (pc_en !== 1'b0 || cp_reset !== 5'b00100 || cp_start !== 5'b0) begin errors++; $display("FAIL basic_rst: pc_en=%b cp_reset=%b cp_start=%b required 0/00100/00000", pc_en, cp_reset, cp_start); end
    checks++; if (cp_a !== 32'd7 || cp_b !== 32'd5 || cp_op !== 2'd1) begin errors++; $display("FAIL basic_latch: a=%0d b=%0d op=%0d required 7/5/1", cp_a, cp_b, cp_op); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (pc_en !== 1'b0 || cp_start !== 5'b00100 || cp_reset !== 5'b0) begin errors++; $display("FAIL basic_start: pc_en=%b cp_start=%b cp_reset=%b required 0/00100/00000", pc_en, cp_start, cp_reset); end
    @(posedge clk); #1;
    cp_done = 5'b00100; cp_result[2*WIDTH +: WIDTH] = 32'd12;
    @(negedge clk);
    checks++; if (pc_en !== 1'b0 || cp_start !== 5'b0) begin errors++; $display("FAIL basic_wait: pc_en=%b cp_start=%b required 0/00000", pc_en, cp_start); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (pc_en !== 1'b1 || result_valid !== 1'b1 || result !== 32'd12 || error !== 1'b0) begin errors++; $display("FAIL basic_done: pc_en=%b valid=%b result=%0d error=%b required 1/1/12/0", pc_en, result_valid, result, error); end
    @(posedge clk); #1;
    cp_done = '0; cp_result[2*WIDTH +: WIDTH] = 32'd55;
    @(negedge clk);
    checks++; if (result !== 32'd12 || result_valid !== 1'b0 || pc_en !== 1'b1) begin errors++; $display("FAIL basic_hold: result=%0d valid=%b pc_en=%b required 12/0/1", result, result_valid, pc_en); end
  endtask

  task automatic test_unselected_done();
    int st; logic [NUM_CP-1:0] rs, ss;
    do_op(1, 32'h11, 32'h22, 32'hCAFE0001, 1'b0, 10, 5'b01001, 1'b1, 60, st, rs, ss);
    checks++; if (st !== 11) begin errors++; $display("FAIL unsel_stall: stalls=%0d required 11", st); end
    checks++; if (rs !== 5'b00010 || ss !== 5'b00010) begin errors++; $display("FAIL unsel_pulses: rst=%b start=%b required 00010/00010", rs, ss); end
  endtask

  task automatic test_bad_sel();
    int st; logic [NUM_CP-1:0] rs, ss;
    do_op(5, 32'h1, 32'h2, 32'h3, 1'b1, 0, 5'b11111, 1'b1, 20, st, rs, ss);
    checks++; if (st !== 1) begin errors++; $display("FAIL badsel5_stall: stalls=%0d required 1", st); end
    checks++; if (rs !== '0 || ss !== '0) begin errors++; $display("FAIL badsel5_pulses: rst=%b start=%b required 0", rs, ss); end
    checks++; if (result !== '0 || error !== 1'b1) begin errors++; $display("FAIL badsel5_out: result=%h error=%b required 0/1", result, error); end
    do_op(7, 32'h4, 32'h5, 32'h6, 1'b1, 0, '0, 1'b1, 20, st, rs, ss);
    checks++; if (st !== 1 || rs !== '0 || ss !== '0) begin errors++; $display("FAIL badsel7: stalls=%0d rst=%b start=%b required 1/0/0", st, rs, ss); end
  endtask

  task automatic test_back_to_back();
    int sels[6]    = '{0, 4, 2, 6, 3, 1};
    int done_at[6] = '{3, 5, 0, 0, 4, 3};
    int st, exp_st; logic [NUM_CP-1:0] rs, ss, em; bit err;
    for (int i = 0; i < 6; i++) begin
      err = (sels[i] >= NUM_CP);
      em = '0;
      if (!err) em[sels[i]] = 1'b1;
      exp_st = err ? 1 : ((done_at[i] <= 3) ? 4 : done_at[i] + 1);
      do_op(sels[i], WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom) | 32'h1, err,
            done_at[i], '0, 1'b1, 60, st, rs, ss);
      checks++; if (st !== exp_st) begin errors++; $display("FAIL b2b_stall[%0d]: stalls=%0d required %0d", i, st, exp_st); end
      checks++; if (rs !== em || ss !== em) begin errors++; $display("FAIL b2b_pulses[%0d]: rst=%b start=%b required %b", i, rs, ss, em); end
    end
  endtask

  task automatic test_midop_reset();
    int st; logic [NUM_CP-1:0] rs, ss;
    @(posedge clk); #1;
    issue = 1'b1; cp_sel = 3'd3; src_a = 32'hA5A5A5A5; src_b = 32'h5A5A5A5A; op = 2'd2;
    cp_done = '0;
    cp_result[3*WIDTH +: WIDTH] = 32'h0BADF00D;
    @(posedge clk); #1; issue = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL midrst_waiting: pc_en=%b required 0", pc_en); end
    @(posedge clk); #1;
    reset = 1'b1; cp_done = 5'b01000;
    @(negedge clk);
    checks++; if (pc_en !== 1'b1 || result_valid !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: pc_en=%b valid=%b error=%b required 1/0/0", pc_en, result_valid, error); end
    checks++; if (result !== '0 || cp_a !== '0 || cp_b !== '0 || cp_op !== '0) begin errors++; $display("FAIL midrst_data: result=%h a=%h b=%h op=%h required 0", result, cp_a, cp_b, cp_op); end
    checks++; if (cp_reset !== '0 || cp_start !== '0) begin errors++; $display("FAIL midrst_pulses: rst=%b start=%b required 0", cp_reset, cp_start); end
    @(posedge clk); #1;
    reset = 1'b0; cp_done = '0;
    @(negedge clk);
    checks++; if (pc_en !== 1'b1 || result_valid !== 1'b0 || result !== '0) begin errors++; $display("FAIL midrst_idle: pc_en=%b valid=%b result=%h required 1/0/0", pc_en, result_valid, result); end
    do_op(4, 32'h3, 32'h4, 32'h00C0FFEE, 1'b0, 3, '0, 1'b1, 60, st, rs, ss);
    checks++; if (st !== 4 || rs !== 5'b10000) begin errors++; $display("FAIL midrst_recover: stalls=%0d rst=%b required 4/10000", st, rs); end
  endtask

  task automatic test_timeout();
    int st; logic [NUM_CP-1:0] rs, ss;
`ifdef CP_TIMEOUT_EN
    do_op(4, 32'h9, 32'h8, 32'h77, 1'b1, 100000, 5'b01111, 1'b1, 60, st, rs, ss);
    checks++; if (st !== 3 + TIMEOUT) begin errors++; $display("FAIL timeout_stall: stalls=%0d required %0d", st, 3 + TIMEOUT); end
    checks++; if (result !== '0 || error !== 1'b1) begin errors++; $display("FAIL timeout_out: result=%h error=%b required 0/1", result, error); end
`else
    do_op(4, 32'h9, 32'h8, 32'h77, 1'b0, 100000, 5'b01111, 1'b0, 120, st, rs, ss);
    checks++; if (st !== 120) begin errors++; $display("FAIL nolimit_stall: stalls=%0d required 120", st); end
    @(posedge clk); #1;
    reset = 1'b1; cp_done = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL nolimit_reset: pc_en=%b required 1", pc_en); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unselected_done();
    test_bad_sel();
    test_back_to_back();
    test_midop_reset();
    test_timeout();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_retires: %0d outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
